// File: rtl/rf_lvt_multiport_if.sv
// Write/read bus of the LVT multi-port register file: per-port enables,
// addresses and data packed into flat vectors, plus the ready flag.
interface rf_lvt_multiport_if #(
    parameter int NUM_WRITE = 3,
    parameter int NUM_READ  = 8,
    parameter int SIZE      = 64,
    parameter int WIDTH     = 32
);
    localparam int ADDR_W = $clog2(SIZE);

    logic [NUM_WRITE-1:0]        wen;
    logic [NUM_WRITE*ADDR_W-1:0] waddr;
    logic [NUM_WRITE*WIDTH-1:0]  wdata;
    logic [NUM_READ*ADDR_W-1:0]  raddr;
    logic [NUM_READ*WIDTH-1:0]   rdata;
    logic                        ready;

    modport master (
        output wen, waddr, wdata, raddr,
        input  rdata, ready
    );

    modport slave (
        input  wen, waddr, wdata, raddr,
        output rdata, ready
    );
endinterface

// File: rtl/rf_lvt_multiport.sv
// Multi-write/multi-read register file: one 1W/NR-R RAM bank per write port,
// a live-value table picks the newest bank per entry; zero-init after reset.
module rf_lvt_multiport #(
    parameter int NUM_WRITE = 3,
    parameter int NUM_READ  = 8,
    parameter int SIZE      = 64,
    parameter int WIDTH     = 32,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_lvt_multiport_if.slave bus
);
    localparam int ADDR_W = $clog2(SIZE);
    localparam int SEL_W  = (NUM_WRITE > 1) ? $clog2(NUM_WRITE) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   init_cnt_reg;
    logic                ready_reg;

    logic [ADDR_W-1:0]   wa [NUM_WRITE];
    logic [WIDTH-1:0]    wd [NUM_WRITE];
    logic [ADDR_W-1:0]   ra [NUM_READ];
    logic [NUM_WRITE-1:0] wr_ok;
    logic [SEL_W-1:0]    lvt_reg [SIZE];
    logic [NUM_READ*WIDTH-1:0] bank_rd [NUM_WRITE];

    logic in_init;
    assign in_init   = (state_reg == ST_INIT);
    assign bus.ready = ready_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            ready_reg    <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            init_cnt_reg <= init_cnt_reg + 1'b1;
            if (init_cnt_reg == ADDR_W'(SIZE - 1)) begin
                state_reg <= ST_RUN;
                ready_reg <= 1'b1;
            end
        end
    end

    // Writes to entry 0 are dropped entirely when it is the hardwired zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WRITE; gi++) begin : g_wport
            assign wa[gi]    = bus.waddr[gi*ADDR_W +: ADDR_W];
            assign wd[gi]    = bus.wdata[gi*WIDTH +: WIDTH];
            assign wr_ok[gi] = !in_init && bus.wen[gi] &&
                               !((ZERO_REG != 0) && (wa[gi] == '0));
        end

        for (gi = 0; gi < NUM_READ; gi++) begin : g_raddr
            assign ra[gi] = bus.raddr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Later ports overwrite earlier ones, so the highest-index port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                lvt_reg[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_ok[w]) begin
                    lvt_reg[wa[w]] <= SEL_W'(w);
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_WRITE; gi++) begin : g_bank
            logic [WIDTH-1:0]          mem [SIZE];
            logic [NUM_READ*WIDTH-1:0] rd_reg;
            logic                      we;
            logic [ADDR_W-1:0]         addr;
            logic [WIDTH-1:0]          data;

            assign we   = in_init || wr_ok[gi];
            assign addr = in_init ? init_cnt_reg : wa[gi];
            assign data = in_init ? '0 : wd[gi];

            // Read-first RAM: a same-edge write is not visible to the read.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[addr] <= data;
                end
                for (int r = 0; r < NUM_READ; r++) begin
                    rd_reg[r*WIDTH +: WIDTH] <= mem[ra[r]];
                end
            end

            assign bank_rd[gi] = rd_reg;
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rport
            logic [SEL_W-1:0] sel_reg;
            logic             hit_reg;
            logic [WIDTH-1:0] byp_reg;
            logic             force0_reg;
            logic             hit_next;
            logic [WIDTH-1:0] byp_next;

            always_comb begin
                hit_next = 1'b0;
                byp_next = '0;
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WRITE; w++) begin
                        if (wr_ok[w] && (wa[w] == ra[gi])) begin
                            hit_next = 1'b1;
                            byp_next = wd[w];
                        end
                    end
                end
            end

            // A read sampled during INIT may see an entry not yet cleared.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_reg    <= '0;
                    hit_reg    <= 1'b0;
                    byp_reg    <= '0;
                    force0_reg <= 1'b1;
                end else begin
                    sel_reg    <= lvt_reg[ra[gi]];
                    hit_reg    <= hit_next;
                    byp_reg    <= byp_next;
                    force0_reg <= in_init || ((ZERO_REG != 0) && (ra[gi] == '0));
                end
            end

            assign bus.rdata[gi*WIDTH +: WIDTH] =
                (!ready_reg || force0_reg) ? '0 :
                hit_reg ? byp_reg : bank_rd[sel_reg][gi*WIDTH +: WIDTH];
        end
    endgenerate
endmodule

// File: tb/tb_rf_lvt_multiport.sv
// Randomised bench for rf_lvt_multiport against an array model of the
// register file that applies writes and reads by the documented rules.
module tb_rf_lvt_multiport;
    localparam int NW  = 3;
    localparam int NR  = 8;
    localparam int SZ  = 64;
    localparam int W   = 32;
    localparam int BYP = 1;
    localparam int ZR  = 1;
    localparam int AW  = $clog2(SZ);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_lvt_multiport_if #(.NUM_WRITE(NW), .NUM_READ(NR), .SIZE(SZ), .WIDTH(W)) bus ();

    rf_lvt_multiport #(
        .NUM_WRITE(NW), .NUM_READ(NR), .SIZE(SZ), .WIDTH(W),
        .BYPASS(BYP), .ZERO_REG(ZR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] model [SZ];
    logic [W-1:0] exp_q [NR];

    task automatic clear_model();
        for (int i = 0; i < SZ; i++) model[i] = '0;
    endtask

    task automatic set_idle();
        bus.wen   = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr = '0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [W-1:0] d);
        bus.wen[p] = 1'b1;
        bus.waddr[p*AW +: AW] = AW'(a);
        bus.wdata[p*W +: W] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.raddr[p*AW +: AW] = AW'(a);
    endtask

    // Expected read results for this cycle, then the cycle's writes, then the edge.
    task automatic tick();
        logic [AW-1:0] a;
        logic [W-1:0]  v;
        for (int r = 0; r < NR; r++) begin
            a = bus.raddr[r*AW +: AW];
            if (ZR != 0 && a == 0) begin
                exp_q[r] = '0;
            end else begin
                v = model[a];
                if (BYP != 0)
                    for (int w = 0; w < NW; w++)
                        if (bus.wen[w] && bus.waddr[w*AW +: AW] == a) v = bus.wdata[w*W +: W];
                exp_q[r] = v;
            end
        end
        for (int w = 0; w < NW; w++) begin
            a = bus.waddr[w*AW +: AW];
            if (bus.wen[w] && !(ZR != 0 && a == 0)) model[a] = bus.wdata[w*W +: W];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        set_idle();
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", bus.ready);
        end
        checks++;
        if (bus.rdata !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
        end
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 200) begin
            for (int w = 0; w < NW; w++) set_wr(w, $urandom_range(0, SZ-1), $urandom | 32'h1);
            for (int r = 0; r < NR; r++) set_rd(r, $urandom_range(0, SZ-1));
            @(posedge clk);
            #1;
            n++;
            checks++;
            if (bus.rdata !== '0) begin
                errors++; $display("FAIL init_rdata cycle %0d: got %h want 0", n, bus.rdata);
            end
        end
        $display("txn init: ready after %0d cycles", n);
        checks++;
        if (n != SZ) begin
            errors++; $display("FAIL init_length: got %0d cycles want %0d", n, SZ);
        end
        set_idle();
        for (int c = 0; c < SZ / NR; c++) begin
            for (int r = 0; r < NR; r++) set_rd(r, c*NR + r);
            tick();
            $display("txn init_read: block %0d rdata=%h", c, bus.rdata);
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (bus.rdata[r*W +: W] !== 32'h0) begin
                    errors++; $display("FAIL init_clear addr %0d: got %h want 00000000", c*NR + r, bus.rdata[r*W +: W]);
                end
            end
        end
    endtask

    task automatic test_basic();
        set_idle();
        set_wr(1, 'h12, 32'hDEADBEEF);
        tick();
        set_idle();
        for (int r = 0; r < NR; r++) set_rd(r, 'h12);
        tick();
        $display("txn basic: read 0x12 rdata[0]=%h", bus.rdata[W-1:0]);
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (bus.rdata[r*W +: W] !== 32'hDEADBEEF) begin
                errors++; $display("FAIL basic port %0d: got %h want deadbeef", r, bus.rdata[r*W +: W]);
            end
        end
    endtask

    task automatic test_collision();
        logic [W-1:0] want;
        set_idle();
        set_wr(0, 5, 32'h11111111);
        set_wr(1, 5, 32'h22222222);
        set_wr(2, 5, 32'h33333333);
        tick();
        set_idle();
        set_rd(0, 5);
        tick();
        $display("txn collision: read 0x05 rdata=%h", bus.rdata[W-1:0]);
        checks++;
        if (bus.rdata[W-1:0] !== 32'h33333333) begin
            errors++; $display("FAIL collision_win: got %h want 33333333", bus.rdata[W-1:0]);
        end
        set_wr(0, 5, 32'h44);
        tick();
        want = (BYP != 0) ? 32'h44 : 32'h33333333;
        checks++;
        if (bus.rdata[W-1:0] !== want) begin
            errors++; $display("FAIL collision_rdw: got %h want %h", bus.rdata[W-1:0], want);
        end
        set_idle();
        set_rd(0, 5);
        tick();
        $display("txn collision: reread 0x05 rdata=%h", bus.rdata[W-1:0]);
        checks++;
        if (bus.rdata[W-1:0] !== 32'h44) begin
            errors++; $display("FAIL collision_port0: got %h want 00000044", bus.rdata[W-1:0]);
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] want;
        set_idle();
        set_wr(0, 7, 32'hAAAA);
        tick();
        set_idle();
        set_wr(2, 7, 32'hBBBB);
        set_rd(3, 7);
        tick();
        want = (BYP != 0) ? 32'hBBBB : 32'hAAAA;
        $display("txn bypass: same-cycle rdata[3]=%h", bus.rdata[3*W +: W]);
        checks++;
        if (bus.rdata[3*W +: W] !== want) begin
            errors++; $display("FAIL bypass_same: got %h want %h", bus.rdata[3*W +: W], want);
        end
        set_idle();
        set_rd(3, 7);
        tick();
        checks++;
        if (bus.rdata[3*W +: W] !== 32'hBBBB) begin
            errors++; $display("FAIL bypass_next: got %h want 0000bbbb", bus.rdata[3*W +: W]);
        end
    endtask

    task automatic test_zero_reg();
        set_idle();
        set_wr(2, 1, 32'hC0FFEE01);
        tick();
        set_idle();
        set_wr(1, 0, 32'h1234);
        tick();
        set_idle();
        set_rd(0, 0);
        set_rd(1, 1);
        tick();
        $display("txn zero: r0=%h r1=%h", bus.rdata[W-1:0], bus.rdata[W +: W]);
        checks++;
        if (bus.rdata[W-1:0] !== 32'h0) begin
            errors++; $display("FAIL zero_read: got %h want 00000000", bus.rdata[W-1:0]);
        end
        checks++;
        if (bus.rdata[W +: W] !== 32'hC0FFEE01) begin
            errors++; $display("FAIL zero_lvt: got %h want c0ffee01", bus.rdata[W +: W]);
        end
    endtask

    task automatic test_random();
        int nerr;
        for (int c = 0; c < 300; c++) begin
            set_idle();
            for (int w = 0; w < NW; w++) begin
                bus.wen[w] = 1'($urandom);
                bus.waddr[w*AW +: AW] = AW'((c % 2 != 0) ? $urandom_range(0, 7) : $urandom_range(0, SZ-1));
                bus.wdata[w*W +: W] = $urandom;
            end
            for (int r = 0; r < NR; r++)
                set_rd(r, (c % 2 != 0) ? $urandom_range(0, 7) : $urandom_range(0, SZ-1));
            tick();
            nerr = 0;
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (bus.rdata[r*W +: W] !== exp_q[r]) begin
                    errors++; nerr++;
                    $display("FAIL random cycle %0d port %0d: got %h want %h", c, r, bus.rdata[r*W +: W], exp_q[r]);
                end
            end
            $display("txn random %0d: wen=%b bad_ports=%0d", c, bus.wen, nerr);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        for (int a = 1; a < SZ; a += NW) begin
            set_idle();
            for (int w = 0; w < NW; w++)
                if (a + w < SZ) set_wr(w, a + w, $urandom | 32'h1);
            tick();
        end
        set_idle();
        for (int r = 0; r < NR; r++) set_rd(r, r + 1);
        tick();
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (bus.rdata[r*W +: W] !== exp_q[r] || exp_q[r] == 0) begin
                errors++; $display("FAIL fill port %0d: got %h want %h", r, bus.rdata[r*W +: W], exp_q[r]);
            end
        end
        rst_n = 1'b0;
        #2;
        $display("txn mid_reset: ready=%b", bus.ready);
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++; $display("FAIL async_ready: got %b want 0", bus.ready);
        end
        checks++;
        if (bus.rdata !== '0) begin
            errors++; $display("FAIL async_rdata: got %h want 0", bus.rdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        n = 0;
        while (!bus.ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != SZ) begin
            errors++; $display("FAIL reinit_length: got %0d cycles want %0d", n, SZ);
        end
        for (int c = 0; c < SZ / NR; c++) begin
            for (int r = 0; r < NR; r++) set_rd(r, c*NR + r);
            tick();
            $display("txn reinit_read: block %0d", c);
            for (int r = 0; r < NR; r++) begin
                checks++;
                if (bus.rdata[r*W +: W] !== 32'h0) begin
                    errors++; $display("FAIL reinit_clear addr %0d: got %h want 00000000", c*NR + r, bus.rdata[r*W +: W]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_collision();
        test_bypass();
        test_zero_reg();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_lvt_multiport.md
Name: rf_lvt_multiport

Overview:
- Parametrised multi-write, multi-read integer physical register file for the SoomRV FPGA build.
- Built from NUM_WRITE replicated 1W/NUM_READ-R block-RAM banks, one bank per write port, plus a flop-based live-value table (LVT) recording which bank holds the newest copy of each entry.
- Adds features the fixed 3W/8R file lacks:
  - generic port counts;
  - hardware zero-init sequencer after reset;
  - optional write-to-read bypass;
  - optional hardwired zero register.

Parameters:
- NUM_WRITE, 3, number of write ports and banks (1..4)
- NUM_READ, 8, number of read ports (1..12)
- SIZE, 64, number of entries (power of two, >=4); ADDR_W = $clog2(SIZE)
- WIDTH, 32, data width in bits
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = read-old-data
- ZERO_REG, 1, 1 = entry 0 reads as 0 and writes to it are dropped

Ports:
- clk, in, 1, clock; all state changes on rising edge
- rst_n, in, 1, asynchronous active-low reset
- wen, in, NUM_WRITE, per-port write enable
- waddr, in, NUM_WRITE*ADDR_W, write addresses; port w uses slice [w*ADDR_W +: ADDR_W]
- wdata, in, NUM_WRITE*WIDTH, write data; port w uses slice [w*WIDTH +: WIDTH]
- raddr, in, NUM_READ*ADDR_W, read addresses; port r uses slice [r*ADDR_W +: ADDR_W]
- rdata, out, NUM_READ*WIDTH, registered read data
- ready, out, 1, high once initialisation is complete

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=INIT, initCnt=0, ready=0, all LVT entries=0, all select and bypass registers=0.
  - rdata is driven 0 while ready=0.
  - Bank RAM contents are not reset directly; the sequencer clears them.
- State machine: INIT -> RUN, and RUN only exits via reset.
  - INIT, each cycle: every bank writes 0 to entry initCnt, and initCnt increments.
  - When initCnt==SIZE-1 has been written, state -> RUN and ready=1 on the next edge.
  - INIT therefore lasts exactly SIZE cycles after rst_n deasserts.
  - External wen is ignored during INIT; the writes are lost and are not queued.
- Reset asserted mid-INIT or mid-RUN restarts INIT from entry 0. Prior RAM contents are irrelevant.
- Write in RUN, per port w with wen[w]:
  - bank w writes wdata[w] at waddr[w];
  - LVT[waddr[w]] <= w.
- Same-address multi-write in one cycle: the highest-index port wins in the LVT. Every bank still writes its own copy.
- ZERO_REG=1 and waddr==0: bank and LVT updates are suppressed.
- Read, latency 1 cycle:
  - raddr[r] sampled at edge N; rdata[r] valid after edge N, i.e. during cycle N+1.
  - Selection: rdata[r] = bank[selReg[r]] output, where selReg[r] is LVT[raddr[r]] registered at edge N.
  - The LVT read uses LVT contents before the edge-N update.
  - No read enable: every port reads every cycle.
- Read-during-write, same address, same cycle:
  - BYPASS=1: rdata returns the winning (highest-index) wdata. The forward value and a hit flag are registered at edge N and muxed over the bank output.
  - BYPASS=0: rdata returns the pre-write value. Banks are read-first; the LVT is read before update.
- Write then read on the next cycle always returns the new data, in both modes.
- ZERO_REG=1 and raddr==0: rdata is 0 regardless of bank contents.
- Throughput: every read and write port can be used every cycle; no back-pressure, no stall output.
- Address range: addresses are exactly ADDR_W bits, so no out-of-range case exists.

Test Plan:
- Init sequence: release rst_n, hold wen=1 during INIT.
  - ready rises exactly 64 cycles after release.
  - All 8 ports reading any address during or after INIT return 0x00000000; INIT-time writes have no effect.
- Basic write/read: port1 writes 0xDEADBEEF to 0x12. Next cycle, raddr[0..7]=0x12 -> all rdata=0xDEADBEEF one cycle later.
- Multi-write collision: in one cycle port0 writes 0x11111111, port1 writes 0x22222222, port2 writes 0x33333333, all to 0x05 -> subsequent read returns 0x33333333. Next cycle port0 writes 0x44 to 0x05 -> read returns 0x44.
- Bypass: 0x07 holds 0xAAAA. Same cycle, port2 writes 0xBBBB to 0x07 and port3 reads 0x07.
  - BYPASS=1 -> 0xBBBB.
  - BYPASS=0 -> 0xAAAA.
  - Either mode, a read on the following cycle -> 0xBBBB.
- Zero register (ZERO_REG=1): write 0x1234 to address 0 -> read of 0 returns 0. LVT entry 0 stays 0, so a later read of 0x01 is unaffected.
- Mid-operation reset: fill 0x01..0x3F with nonzero values, pulse rst_n low for 1 cycle between clock edges -> ready drops immediately (async), 64-cycle INIT reruns, and all entries read 0 afterwards.
